// File: rtl/stamp_result_checker_if.sv
// Measurement bus for stamp_result_checker: sample stream in, status and signature out.
// The bench or controlling logic uses the master modport; the checker uses slave.
interface stamp_result_checker_if;
    logic        i_ena;
    logic        i_start;
    logic [31:0] i_data;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [31:0] o_signature;
    logic [23:0] o_toggles;

    modport master (
        output i_ena, i_start, i_data,
        input  o_busy, o_done, o_pass, o_signature, o_toggles
    );

    modport slave (
        input  i_ena, i_start, i_data,
        output o_busy, o_done, o_pass, o_signature, o_toggles
    );
endinterface

// File: rtl/stamp_result_checker.sv
// MISR signature checker for a pipelined stamp: flush LATENCY samples, fold WINDOW samples, compare.
// Optional macro STAMP_CHK_TOGGLE_CNT_EN adds a saturating input bit-toggle counter.
module stamp_result_checker #(
    parameter int          LATENCY = 6,
    parameter int          WINDOW  = 4096,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] SEED    = 32'hFFFFFFFF,
    parameter logic [31:0] EXP_SIG = 32'h00000000
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    stamp_result_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] FLUSH_LAST = 16'(LATENCY - 1);
    localparam logic [15:0] WIN_LAST   = 16'(WINDOW - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] sig_q, sig_d;
    logic [31:0] sig_fold;

    assign sig_fold = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ bus.i_data;

    // A start pulse wins in every state, so it doubles as abort/restart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        if (bus.i_start) begin
            state_d = (LATENCY == 0) ? ACCUM : FLUSH;
            cnt_d   = 16'd0;
            sig_d   = SEED;
        end else begin
            case (state_q)
                FLUSH: begin
                    if (bus.i_ena) begin
                        if (cnt_q == FLUSH_LAST) begin
                            state_d = ACCUM;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.i_ena) begin
                        sig_d = sig_fold;
                        if (cnt_q == WIN_LAST) begin
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            sig_q   <= SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    assign bus.o_busy      = (state_q == FLUSH) || (state_q == ACCUM);
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_pass      = (state_q == DONE) && (sig_q == EXP_SIG);
    assign bus.o_signature = sig_q;

`ifdef STAMP_CHK_TOGGLE_CNT_EN
    logic [31:0] ref_q, ref_d;
    logic [23:0] tog_q, tog_d;
    logic [24:0] tog_sum;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    assign tog_sum = {1'b0, tog_q} + {19'd0, popcount32(bus.i_data ^ ref_q)};

    // Reference follows the last enabled sample so toggles are measured sample-to-sample.
    always_comb begin
        ref_d = ref_q;
        tog_d = tog_q;
        if (bus.i_start) begin
            ref_d = 32'd0;
            tog_d = 24'd0;
        end else if (bus.i_ena && (state_q == FLUSH)) begin
            ref_d = bus.i_data;
        end else if (bus.i_ena && (state_q == ACCUM)) begin
            ref_d = bus.i_data;
            tog_d = tog_sum[24] ? 24'hFFFFFF : tog_sum[23:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ref_q <= 32'd0;
            tog_q <= 24'd0;
        end else begin
            ref_q <= ref_d;
            tog_q <= tog_d;
        end
    end

    assign bus.o_toggles = tog_q;
`else
    assign bus.o_toggles = 24'h000000;
`endif

endmodule
